// File: rtl/opcode_arbiter.sv
// rtl/opcode_arbiter.sv - two-requester arbiter for the shared sprite-draw opcode path
// Grants A or B, pulses START, holds SEL until DRAW_DONE or watchdog abort, then ACKs.
module opcode_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int RR_MODE = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic REQ_A,
  input  logic REQ_B,
  input  logic DRAW_DONE,
  input  logic ERR_CLR,
  output logic SEL,
  output logic START,
  output logic BUSY,
  output logic ACK_A,
  output logic ACK_B,
  output logic ERR
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t          state_q;
  logic            sel_q;
  logic            last_gnt_q;
  logic            start_q;
  logic            busy_q;
  logic            ack_a_q;
  logic            ack_b_q;
  logic            err_q;
  logic [WD_W-1:0] wdog_q;
  logic            sel_d;

  // Grant choice, only consumed on the IDLE->ISSUE edge.
  always_comb begin
    sel_d = 1'b0;
    if (REQ_A && REQ_B) begin
      sel_d = (RR_MODE != 0) ? ~last_gnt_q : 1'b0;
    end else if (REQ_B) begin
      sel_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
    end else begin
      start_q <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      // A watchdog set later in this block overrides the clear.
      if (ERR_CLR) begin
        err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (REQ_A || REQ_B) begin
            state_q <= S_ISSUE;
            sel_q   <= sel_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          wdog_q  <= '0;
        end
        S_WAIT: begin
          if (DRAW_DONE || (wdog_q == WD_LAST)) begin
            state_q <= S_ACK;
            ack_a_q <= ~sel_q;
            ack_b_q <= sel_q;
            if (!DRAW_DONE) begin
              err_q <= 1'b1;
            end
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        S_ACK: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          last_gnt_q <= sel_q;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign SEL   = sel_q;
  assign START = start_q;
  assign BUSY  = busy_q;
  assign ACK_A = ack_a_q;
  assign ACK_B = ack_b_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_opcode_arbiter.sv
// tb/tb_opcode_arbiter.sv - scoreboard bench for opcode_arbiter, round-robin and fixed-priority lanes
module tb_opcode_arbiter;

  localparam int TMO = 8;

  typedef struct {
    bit who;
    int lat;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int RR = (g == 0) ? 1 : 0;

    logic req_a, req_b, done, err_clr;
    logic sel, start, busy, ack_a, ack_b, err;
    exp_t exp_q[$];
    int   dly_q[$];
    bit   last_gnt, err_cur;
    bit   fin = 1'b0;
    bit   want_rst = 1'b0;
    bit   all_done = 1'b0;

    opcode_arbiter #(.TIMEOUT(TMO), .RR_MODE(RR)) dut (
      .Clk(clk), .Reset(rst), .REQ_A(req_a), .REQ_B(req_b),
      .DRAW_DONE(done), .ERR_CLR(err_clr), .SEL(sel), .START(start),
      .BUSY(busy), .ACK_A(ack_a), .ACK_B(ack_b), .ERR(err)
    );

    // Draw engine: DONE lands in WAIT cycle index d after START (d >= TMO lands after abort).
    int cnt;
    initial begin
      done = 1'b0;
      cnt = 0;
      forever begin
        @(negedge clk);
        done = 1'b0;
        if (rst) begin
          cnt = 0;
        end else begin
          if (cnt > 0) begin
            cnt--;
            if (cnt == 0) done = 1'b1;
          end
          if (start) cnt = ((dly_q.size() > 0) ? dly_q.pop_front() : 0) + 1;
        end
      end
    end

    bit   inflight = 1'b0, post_ack = 1'b0, sel_start, sel_moved;
    int   lat;
    exp_t me;
    always @(negedge clk) begin
      if (rst) begin
        inflight = 1'b0;
        post_ack = 1'b0;
      end else begin
        if (post_ack) begin
          chk("idle_busy", busy, 0);
          chk("idle_start", start, 0);
          chk("idle_sel_kept", sel, sel_start);
          post_ack = 1'b0;
        end
        if (inflight) begin
          lat++;
          if (sel != sel_start) sel_moved = 1'b1;
        end
        if (start) begin
          chk("start_while_busy", inflight, 0);
          chk("busy_at_start", busy, 1);
          inflight = 1'b1;
          lat = 0;
          sel_start = sel;
          sel_moved = 1'b0;
        end
        if (ack_a || ack_b) begin
          chk("ack_onehot", ack_a & ack_b, 0);
          chk("ack_inflight", inflight, 1);
          chk("ack_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("ack_who", ack_b, me.who);
            chk("grant_sel", sel_start, me.who);
            chk("ack_latency", lat, me.lat);
            chk("ack_err", err, me.err);
            chk("sel_stable", sel_moved, 0);
            chk("busy_at_ack", busy, 1);
          end
          inflight = 1'b0;
          post_ack = 1'b1;
        end
      end
    end

    function automatic int pick_delay();
      int r = $urandom_range(0, 9);
      if (r <= 5) return $urandom_range(0, TMO - 2);
      if (r == 6) return TMO - 1;
      if (r == 7) return TMO;
      if (r == 8) return TMO + 1;
      return 0;
    endfunction

    // clr_mode: 0 never clear, 1 random clear (held or pulsed), 2 pulse clear after item.
    task automatic run_item(input int na, input int nb, input int fd, input int clr_mode);
      int   ra, rb, d, guard;
      bit   gs, to, hold_clr, drop_a, drop_b;
      exp_t e;
      hold_clr = (clr_mode == 1) && ($urandom_range(0, 4) == 0);
      ra = na;
      rb = nb;
      while (ra > 0 || rb > 0) begin
        if (ra > 0 && rb > 0) gs = (RR != 0) ? ~last_gnt : 1'b0;
        else gs = (ra == 0);
        d = (fd >= 0) ? fd : pick_delay();
        to = (d >= TMO);
        e.who = gs;
        e.lat = (to ? TMO : d + 1) + 1;
        e.err = to || (err_cur && !hold_clr);
        err_cur = !hold_clr && (err_cur || to);
        exp_q.push_back(e);
        dly_q.push_back(d);
        last_gnt = gs;
        if (gs) rb--;
        else ra--;
      end
      err_clr = hold_clr;
      req_a = (na > 0);
      req_b = (nb > 0);
      ra = na;
      rb = nb;
      drop_a = 1'b0;
      drop_b = 1'b0;
      guard = 0;
      while ((req_a || req_b) && guard < 400) begin
        @(negedge clk);
        guard++;
        if (drop_a) begin req_a = 1'b0; drop_a = 1'b0; end
        if (drop_b) begin req_b = 1'b0; drop_b = 1'b0; end
        if (ack_a) begin ra--; drop_a = (ra <= 0); end
        if (ack_b) begin rb--; drop_b = (rb <= 0); end
      end
      chk("item_complete", guard < 400, 1);
      req_a = 1'b0;
      req_b = 1'b0;
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_idle", err, err_cur);
      if (err_cur && (clr_mode == 2 || (clr_mode == 1 && $urandom_range(0, 1) == 1))) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", err, 0);
        err_cur = 1'b0;
      end
    endtask

    initial begin
      int   na, nb, guard;
      exp_t e;
      req_a = 1'b0;
      req_b = 1'b0;
      err_clr = 1'b0;
      last_gnt = 1'b1;
      err_cur = 1'b0;
      @(negedge clk);
      chk("rst_sel", sel, 0);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack_a", ack_a, 0);
      chk("rst_ack_b", ack_b, 0);
      chk("rst_err", err, 0);
      while (rst !== 1'b0) @(negedge clk);

      run_item(1, 0, 4, 0);
      run_item(2, 2, 2, 0);
      run_item(0, 1, TMO, 2);
      run_item(0, 1, TMO - 1, 0);
      for (int i = 0; i < 40; i++) begin
        na = $urandom_range(0, 3);
        nb = $urandom_range(0, 3);
        if (na == 0 && nb == 0) na = 1;
        run_item(na, nb, -1, 1);
      end
      fin = 1'b1;

      if (g == 0) begin
        guard = 0;
        while (!lane[1].fin && guard < 20000) begin
          @(negedge clk);
          guard++;
        end
        chk("other_lane_fin", lane[1].fin, 1);
        run_item(0, 1, TMO, 0);
        dly_q.push_back(50);
        req_b = 1'b1;
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!start && guard < 20);
        chk("pre_rst_start", start, 1);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_err", err, 1);
        chk("pre_rst_sel", sel, 1);
        want_rst = 1'b1;
        #4;
        chk("async_rst_sel", sel, 0);
        chk("async_rst_start", start, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ack_a", ack_a, 0);
        chk("async_rst_ack_b", ack_b, 0);
        chk("async_rst_err", err, 0);
        last_gnt = 1'b1;
        err_cur = 1'b0;
        e.who = 1'b1;
        e.lat = 4;
        e.err = 1'b0;
        exp_q.push_back(e);
        dly_q.push_back(2);
        guard = 0;
        while (rst !== 1'b0 && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        guard = 0;
        while (!ack_b && guard < 60) begin
          @(negedge clk);
          guard++;
        end
        chk("post_rst_ack_b", ack_b, 1);
        @(negedge clk);
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
      end
      all_done = 1'b1;
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (!lane[0].want_rst && t < 400000) begin
      #1;
      t++;
    end
    chk("rst_request_seen", lane[0].want_rst, 1);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (!(lane[0].all_done && lane[1].fin) && t < 400000) begin
      #1;
      t++;
    end
    chk("bench_complete", lane[0].all_done && lane[1].fin, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
